// File: rtl/counter_ctrl_if.sv
// ---------------------------------------------------------------------------
// counter_ctrl_if
//
// Purpose:
//   Bundles the control/command signals from the timer register block into
//   the counter sequencing controller, and the live status the controller
//   returns.
//
// Signals:
//   timer_en            counting enable, level
//   div_en              prescaler enable
//   div_val[3:0]        prescaler exponent N (divisor 2^N, N in 0..8)
//   halt_req            debug halt request, level
//   dbg_mode            CPU is in debug mode (halt honoured only when 1)
//   counter_clear       single-cycle pulse, zeroes the counter
//   counter_write_sel   bit0 -> low word, bit1 -> high word
//   counter_write_data  data for word writes
//   cnt_val[63:0]       live counter value (registered)
//   halt_ack_status     1 while the controller is HALTED (registered)
//   cnt_tick            1 in every cycle whose closing edge increments
//
// Modports:
//   master  register-block side: drives controls, reads status
//   slave   counter_ctrl side: reads controls, drives status
// ---------------------------------------------------------------------------
interface counter_ctrl_if;
  logic        timer_en;
  logic        div_en;
  logic [3:0]  div_val;
  logic        halt_req;
  logic        dbg_mode;
  logic        counter_clear;
  logic [1:0]  counter_write_sel;
  logic [31:0] counter_write_data;
  logic [63:0] cnt_val;
  logic        halt_ack_status;
  logic        cnt_tick;

  modport master (
    output timer_en,
    output div_en,
    output div_val,
    output halt_req,
    output dbg_mode,
    output counter_clear,
    output counter_write_sel,
    output counter_write_data,
    input  cnt_val,
    input  halt_ack_status,
    input  cnt_tick
  );

  modport slave (
    input  timer_en,
    input  div_en,
    input  div_val,
    input  halt_req,
    input  dbg_mode,
    input  counter_clear,
    input  counter_write_sel,
    input  counter_write_data,
    output cnt_val,
    output halt_ack_status,
    output cnt_tick
  );
endinterface

// File: rtl/counter_ctrl.sv
// ---------------------------------------------------------------------------
// counter_ctrl
//
// Purpose:
//   Sequencing controller for the timer's 64-bit counter. Owns the counter
//   register, the power-of-two prescaler and the debug-halt handshake.
//   A three-state FSM (IDLE / RUN / HALTED) decides when the prescaler runs;
//   the counter increments once per prescaler wrap while in RUN. Clear and
//   word writes are accepted in every state.
//
// Parameters:
//   DIV_W   prescaler counter width, must be >= 8 (largest divisor is 2^8)
//
// Ports:
//   sys_clk    clock
//   sys_rst_n  asynchronous active-low reset
//   bus        counter_ctrl_if.slave: controls in, cnt_val / halt_ack_status /
//              cnt_tick out
// ---------------------------------------------------------------------------
module counter_ctrl #(
  parameter int DIV_W = 8
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  counter_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t            state_q;
  logic              halt_ack_q;
  logic [DIV_W-1:0]  div_cnt_q;
  logic [DIV_W-1:0]  div_cnt_d;
  logic [63:0]       cnt_val_q;
  logic [63:0]       cnt_val_d;
  logic [63:0]       cnt_inc;
  logic [DIV_W:0]    div_span;
  logic [DIV_W:0]    div_span_m1;
  logic [DIV_W-1:0]  div_limit;
  logic              hlt;
  logic              tick;
  logic              write_any;

  // A halt request only counts while the CPU is actually in debug mode.
  assign hlt = bus.halt_req && bus.dbg_mode;

  // Prescaler limit L = 2^N - 1. The span is one bit wider than the counter
  // so that N = 8 with DIV_W = 8 gives 256 - 1 = 255 without overflow.
  assign div_span    = (DIV_W+1)'(1) << bus.div_val;
  assign div_span_m1 = div_span - (DIV_W+1)'(1);
  assign div_limit   = bus.div_en ? div_span_m1[DIV_W-1:0] : '0;

  // Tick depends on the registered state only, so it drops to 0 the cycle
  // after a halt is sampled and immediately on reset.
  assign tick = (state_q == ST_RUN) && (div_cnt_q == div_limit);

  assign write_any = |bus.counter_write_sel;

  // ---------------------------------------------------------------------
  // FSM with registered halt acknowledge
  // ---------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      halt_ack_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hlt) begin
            state_q    <= ST_HALTED;
            halt_ack_q <= 1'b1;
          end else if (bus.timer_en) begin
            state_q    <= ST_RUN;
            halt_ack_q <= 1'b0;
          end else begin
            state_q    <= ST_IDLE;
            halt_ack_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (hlt) begin
            state_q    <= ST_HALTED;
            halt_ack_q <= 1'b1;
          end else if (!bus.timer_en) begin
            state_q    <= ST_IDLE;
            halt_ack_q <= 1'b0;
          end else begin
            state_q    <= ST_RUN;
            halt_ack_q <= 1'b0;
          end
        end
        ST_HALTED: begin
          if (hlt) begin
            state_q    <= ST_HALTED;
            halt_ack_q <= 1'b1;
          end else if (bus.timer_en) begin
            state_q    <= ST_RUN;
            halt_ack_q <= 1'b0;
          end else begin
            state_q    <= ST_IDLE;
            halt_ack_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          halt_ack_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Prescaler next state
  // ---------------------------------------------------------------------
  // Disabling the timer zeroes the prescaler even from HALTED, so a later
  // re-enable always starts a fresh full period. HALTED with the timer
  // still enabled keeps the phase so a resume loses no prescaler cycles.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (!bus.timer_en || (state_q == ST_IDLE)) begin
      div_cnt_d = '0;
    end else if (state_q == ST_RUN) begin
      if (tick) begin
        div_cnt_d = '0;
      end else begin
        // If the limit is lowered below the current count this simply keeps
        // counting and wraps through 2^DIV_W.
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Counter next state: clear > word write > tick
  // ---------------------------------------------------------------------
  // Full 64-bit increment so the carry crosses the word boundary; all-ones
  // wraps to zero.
  assign cnt_inc = cnt_val_q + 64'd1;

  // Each 32-bit word is resolved independently: a write to one word holds
  // the other, and any write drops the increment for that edge.
  for (genvar gi = 0; gi < 2; gi++) begin : g_word
    always_comb begin
      cnt_val_d[gi*32 +: 32] = cnt_val_q[gi*32 +: 32];
      if (bus.counter_clear) begin
        cnt_val_d[gi*32 +: 32] = 32'd0;
      end else if (bus.counter_write_sel[gi]) begin
        cnt_val_d[gi*32 +: 32] = bus.counter_write_data;
      end else if (!write_any && tick) begin
        cnt_val_d[gi*32 +: 32] = cnt_inc[gi*32 +: 32];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_cnt_q <= '0;
      cnt_val_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      cnt_val_q <= cnt_val_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.cnt_val         = cnt_val_q;
  assign bus.halt_ack_status = halt_ack_q;
  assign bus.cnt_tick        = tick;

endmodule

// File: tb/tb_counter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_counter_ctrl
//
// Directed testbench for counter_ctrl. Inputs change just after the falling
// edge; outputs are sampled at the falling edge, half a period away from the
// active rising edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_counter_ctrl;

  logic sys_clk;
  logic sys_rst_n;

  counter_ctrl_if bus_if ();

  counter_ctrl #(.DIV_W(8)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus_if.slave)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic chk_state(input string tag, input logic [63:0] cnt,
                           input logic ack, input logic tck);
    check({tag, ".cnt"},  bus_if.cnt_val, cnt);
    check({tag, ".ack"},  64'(bus_if.halt_ack_status), 64'(ack));
    check({tag, ".tick"}, 64'(bus_if.cnt_tick), 64'(tck));
  endtask

  // Watchdog: the bench only uses bounded waits, this guards against a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sys_rst_n                 = 1'b0;
    bus_if.timer_en           = 1'b0;
    bus_if.div_en             = 1'b0;
    bus_if.div_val            = 4'd0;
    bus_if.halt_req           = 1'b0;
    bus_if.dbg_mode           = 1'b0;
    bus_if.counter_clear      = 1'b0;
    bus_if.counter_write_sel  = 2'b00;
    bus_if.counter_write_data = 32'd0;

    // ---------------- reset values ----------------
    #1;
    chk_state("reset", 64'd0, 1'b0, 1'b0);
    step(2);
    sys_rst_n = 1'b1;
    step(1);
    chk_state("post_reset_idle", 64'd0, 1'b0, 1'b0);
    $display("txn reset_values done");

    // ---------------- prescaler N=3 ----------------
    bus_if.div_en   = 1'b1;
    bus_if.div_val  = 4'd3;
    bus_if.timer_en = 1'b1;
    step(1);                              // edge E passed, now RUN
    for (int i = 0; i < 40; i++) begin
      check($sformatf("div8.tick[%0d]", i), 64'(bus_if.cnt_tick),
            64'((i % 8) == 7));
      step(1);
    end
    check("div8.cnt", bus_if.cnt_val, 64'd5);
    bus_if.timer_en      = 1'b0;
    bus_if.counter_clear = 1'b1;
    step(1);
    bus_if.counter_clear = 1'b0;
    check("div8.cleared", bus_if.cnt_val, 64'd0);
    $display("txn prescaler_div8 done");

    // ---------------- undivided ----------------
    bus_if.div_en   = 1'b0;
    bus_if.timer_en = 1'b1;
    step(1);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("div1.tick[%0d]", i), 64'(bus_if.cnt_tick), 64'd1);
      step(1);
    end
    check("div1.cnt", bus_if.cnt_val, 64'd10);
    bus_if.timer_en      = 1'b0;
    bus_if.counter_clear = 1'b1;
    step(1);
    bus_if.counter_clear = 1'b0;
    check("div1.cleared", bus_if.cnt_val, 64'd0);
    $display("txn prescaler_div1 done");

    // ---------------- carry 31 -> 32 ----------------
    bus_if.counter_write_sel  = 2'b01;
    bus_if.counter_write_data = 32'hFFFF_FFFF;
    step(1);
    bus_if.counter_write_sel  = 2'b00;
    check("carry.load", bus_if.cnt_val, 64'h0000_0000_FFFF_FFFF);
    bus_if.timer_en = 1'b1;
    step(1);                              // E
    step(1);                              // E+1 increments
    check("carry.tick", bus_if.cnt_val, 64'h0000_0001_0000_0000);
    // Still RUN in this cycle, so the edge that samples timer_en=0 counts.
    bus_if.timer_en = 1'b0;
    step(1);
    check("carry.last_tick", bus_if.cnt_val, 64'h0000_0001_0000_0001);
    step(1);
    chk_state("carry.idle", 64'h0000_0001_0000_0001, 1'b0, 1'b0);
    $display("txn carry done");

    // ---------------- full wrap ----------------
    bus_if.counter_write_sel  = 2'b11;
    bus_if.counter_write_data = 32'hFFFF_FFFF;
    step(1);
    bus_if.counter_write_sel  = 2'b00;
    check("wrap.load", bus_if.cnt_val, 64'hFFFF_FFFF_FFFF_FFFF);
    bus_if.timer_en = 1'b1;
    step(2);
    check("wrap.zero", bus_if.cnt_val, 64'd0);
    bus_if.timer_en      = 1'b0;
    bus_if.counter_clear = 1'b1;          // clear beats the concurrent tick
    step(1);
    bus_if.counter_clear = 1'b0;
    check("wrap.clear_over_tick", bus_if.cnt_val, 64'd0);
    $display("txn wrap done");

    // ---------------- priority ----------------
    bus_if.counter_write_sel  = 2'b10;
    bus_if.counter_write_data = 32'h0000_0007;
    step(1);
    bus_if.counter_write_sel  = 2'b00;
    check("prio.hi_load", bus_if.cnt_val, 64'h0000_0007_0000_0000);
    bus_if.timer_en = 1'b1;
    step(2);
    check("prio.run", bus_if.cnt_val, 64'h0000_0007_0000_0001);
    check("prio.tick_present", 64'(bus_if.cnt_tick), 64'd1);
    bus_if.counter_write_sel  = 2'b01;
    bus_if.counter_write_data = 32'h0000_00A5;
    step(1);
    bus_if.counter_write_sel  = 2'b00;
    check("prio.write_over_tick", bus_if.cnt_val, 64'h0000_0007_0000_00A5);
    step(1);
    check("prio.resume", bus_if.cnt_val, 64'h0000_0007_0000_00A6);
    bus_if.counter_clear      = 1'b1;
    bus_if.counter_write_sel  = 2'b11;
    bus_if.counter_write_data = 32'h0000_1234;
    step(1);
    bus_if.counter_clear      = 1'b0;
    bus_if.counter_write_sel  = 2'b00;
    check("prio.clear_over_write", bus_if.cnt_val, 64'd0);
    step(1);
    check("prio.after_clear", bus_if.cnt_val, 64'd1);
    bus_if.timer_en      = 1'b0;
    bus_if.counter_clear = 1'b1;
    step(1);
    bus_if.counter_clear = 1'b0;
    step(1);
    chk_state("prio.idle", 64'd0, 1'b0, 1'b0);
    $display("txn priority done");

    // ---------------- halt, N=2 ----------------
    bus_if.div_en   = 1'b1;
    bus_if.div_val  = 4'd2;
    bus_if.dbg_mode = 1'b1;
    bus_if.timer_en = 1'b1;
    step(1);                              // E, div_cnt=0
    step(2);                              // div_cnt=2, mid-period
    chk_state("halt.pre", 64'd0, 1'b0, 1'b0);
    bus_if.halt_req = 1'b1;
    step(1);                              // H
    chk_state("halt.ack", 64'd0, 1'b1, 1'b0);
    step(5);
    chk_state("halt.frozen", 64'd0, 1'b1, 1'b0);
    bus_if.halt_req = 1'b0;
    step(1);                              // R, div_cnt kept at 3
    chk_state("halt.release", 64'd0, 1'b0, 1'b1);
    step(1);
    chk_state("halt.first_inc", 64'd1, 1'b0, 1'b0);
    $display("txn halt done");

    // ---------------- halt ignored outside debug ----------------
    bus_if.dbg_mode = 1'b0;
    bus_if.halt_req = 1'b1;
    step(4);
    chk_state("nodbg.counting", 64'd2, 1'b0, 1'b0);
    bus_if.halt_req = 1'b0;
    bus_if.dbg_mode = 1'b1;
    $display("txn halt_no_dbg done");

    // ---------------- disable with clear, re-enable ----------------
    step(2);                              // leave prescaler mid-period
    bus_if.timer_en      = 1'b0;
    bus_if.counter_clear = 1'b1;
    step(1);
    bus_if.counter_clear = 1'b0;
    chk_state("disable.clear", 64'd0, 1'b0, 1'b0);
    step(1);
    bus_if.timer_en = 1'b1;
    step(1);                              // E
    step(3);
    chk_state("reenable.wait", 64'd0, 1'b0, 1'b1);
    step(1);
    check("reenable.first_inc", bus_if.cnt_val, 64'd1);
    $display("txn disable_reenable done");

    // ---------------- async reset mid-run ----------------
    bus_if.div_en             = 1'b0;
    bus_if.counter_write_sel  = 2'b11;
    bus_if.counter_write_data = 32'd0;
    step(1);
    bus_if.counter_write_sel  = 2'b01;
    bus_if.counter_write_data = 32'h0000_1234;
    step(1);
    bus_if.counter_write_sel  = 2'b00;
    check("rst.preload", bus_if.cnt_val, 64'h1234);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk_state("rst.async", 64'd0, 1'b0, 1'b0);
    step(1);
    sys_rst_n = 1'b1;
    step(1);                              // IDLE -> RUN, nothing counted yet
    check("rst.restart", bus_if.cnt_val, 64'd0);
    step(1);
    check("rst.first_inc", bus_if.cnt_val, 64'd1);
    $display("txn async_reset done");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
